// File: rtl/alu_writeback_buffer.sv
// Result queue between the ALU and the writeback/bypass port.
// Latency: 1 cycle from push to head. With ALU_WB_BYPASS_EN, an empty buffer passes the input through with 0 cycles.
// Backpressure: in_ready_o drops only when all DEPTH entries are occupied; out_ready_i stalls the head in place.
//
// Optional feature macro: ALU_WB_BYPASS_EN
//   When defined, an empty buffer drives the incoming ALU result straight to
//   out_* in the same cycle. If the writeback port accepts it, nothing is stored.
//   When undefined, there is no combinational path from in_* to out_*.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   flush_i               recovery flush; drops every entry and this cycle's input
//   in_valid_i/in_ready_o ALU-side handshake
//   in_data_i, in_cout_i, in_flags_i, in_tag_i   ALU result payload
//   out_valid_o/out_ready_i  writeback-side handshake
//   out_data_o, out_cout_o, out_flags_o, out_tag_o   head payload (all zero when not valid)
//   count_o               number of stored entries (a bypassed item is never counted)
module alu_writeback_buffer #(
    parameter int DATA_W = 32,
    parameter int FLAG_W = 6,
    parameter int TAG_W  = 7,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DATA_W-1:0]          in_data_i,
    input  logic                       in_cout_i,
    input  logic [FLAG_W-1:0]          in_flags_i,
    input  logic [TAG_W-1:0]           in_tag_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DATA_W-1:0]          out_data_o,
    output logic                       out_cout_o,
    output logic [FLAG_W-1:0]          out_flags_o,
    output logic [TAG_W-1:0]           out_tag_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              cout;
        logic [FLAG_W-1:0] flags;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    // Payload storage. It is not reset: validity is tracked by count alone.
    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    entry_t in_ent;
    entry_t head_ent;
    entry_t out_ent;
    logic   full;
    logic   empty;
    logic   push;
    logic   pop;
    logic   byp_vld;
    logic   byp_take;

    assign in_ent = '{data: in_data_i, cout: in_cout_i, flags: in_flags_i, tag: in_tag_i};
    assign head_ent = mem[rd_ptr];

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Ready is a function of registered occupancy only, so it never depends on out_ready_i.
    assign in_ready_o = ~full;

`ifdef ALU_WB_BYPASS_EN
    // An empty buffer offers the live input. If it is taken this cycle, it is never written.
    assign byp_vld  = empty & in_valid_i & ~flush_i;
    assign byp_take = byp_vld & out_ready_i;
`else
    assign byp_vld  = 1'b0;
    assign byp_take = 1'b0;
`endif

    assign push = in_valid_i & ~full & ~flush_i & ~byp_take;
    // Popping works on stored entries only. A bypassed item is consumed through byp_take.
    assign pop  = ~empty & out_ready_i & ~flush_i;

    always_comb begin
        out_ent = '0;
        if (!empty) begin
            out_ent = head_ent;
        end else if (byp_vld) begin
            out_ent = in_ent;
        end
    end

    assign out_valid_o = ~empty | byp_vld;
    assign out_data_o  = out_ent.data;
    assign out_cout_o  = out_ent.cout;
    assign out_flags_o = out_ent.flags;
    assign out_tag_o   = out_ent.tag;
    assign count_o     = count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_ent;
        end
    end

    // Reset takes priority over flush. Both discard every queued entry at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ONE_PTR;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE_PTR;
            end
            unique case ({push, pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
        end
    end

endmodule
